// File: rtl/prog_loader_pkg.sv
// Shared state type and address-map constants for the program loader.
// PROG_LOADER_READBACK_EN adds the SRAM read states MRD/MWAIT.
package prog_loader_pkg;
    localparam logic [11:0] CTRL_OFF   = 12'h800;
    localparam logic [11:0] STATUS_OFF = 12'h804;
    localparam logic [11:0] MEM_LIMIT  = 12'h7FC;
    localparam int          CNT_W      = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MWR,
`ifdef PROG_LOADER_READBACK_EN
        S_MRD,
        S_MWAIT,
`endif
        S_REG,
        S_DONE
    } state_t;
endpackage

// File: rtl/prog_loader_if.sv
// Wishbone classic slave bus between the management SoC and the loader.
interface prog_loader_if;
    import prog_loader_pkg::*;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                    input  wbs_ack_o, wbs_dat_o);
    modport slave  (input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                    output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/mem_port_mux.sv
// RUN-selected SRAM port mux: loader registers when stopped, CPU pass-through when running.
module mem_port_mux
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              run,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_din,
    input  logic              ld_csb,
    input  logic              ld_web,
    input  logic [1:0]        ld_wmask,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    input  logic              cpu_csb,
    input  logic              cpu_web,
    output logic [DATA_W-1:0] cpu_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_csb,
    output logic              mem_web,
    output logic [1:0]        mem_wmask
);
    always_comb begin
        mem_addr  = ld_addr;
        mem_din   = ld_din;
        mem_csb   = ld_csb;
        mem_web   = ld_web;
        mem_wmask = ld_wmask;
        cpu_din   = '0;
        if (run) begin
            mem_addr  = cpu_addr;
            mem_din   = cpu_dout;
            mem_csb   = cpu_csb;
            mem_web   = cpu_web;
            mem_wmask = 2'b11;
            cpu_din   = mem_dout;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Wishbone program loader and SRAM port arbiter for the 16-bit CPU.
// Define PROG_LOADER_READBACK_EN to enable SRAM readback over Wishbone.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 16,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic              clk,
    input  logic              rst,
    prog_loader_if.slave      wb,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    input  logic              cpu_csb,
    input  logic              cpu_web,
    output logic [DATA_W-1:0] cpu_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_csb,
    output logic              mem_web,
    output logic [1:0]        mem_wmask,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              cpu_rst_o
);
    state_t            state;
    logic              run;
    logic [CNT_W-1:0]  count;
    logic [11:0]       req_off;
    logic              req_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_din;
    logic              ld_csb, ld_web;
    logic [1:0]        ld_wmask;

    logic [31:0] off_full;
    logic [11:0] off;
    logic        hit, is_mem;
    assign off_full = wb.wbs_adr_i - BASE_ADR;
    assign off      = off_full[11:0];
    assign hit      = (off_full[31:12] == '0);
    assign is_mem   = (off <= MEM_LIMIT);

    logic unused_ok;
    assign unused_ok = ^{wb.wbs_sel_i[3:2], wb.wbs_dat_i[31:DATA_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
            ld_addr      <= '0;
            ld_din       <= '0;
            ld_csb       <= 1'b1;
            ld_web       <= 1'b1;
            ld_wmask     <= '0;
            run          <= 1'b0;
            count        <= '0;
            req_off      <= '0;
            req_we       <= 1'b0;
            cpu_rst_o    <= 1'b1;
        end else begin
            cpu_rst_o    <= ~run;
            wb.wbs_ack_o <= 1'b0;
            ld_csb       <= 1'b1;
            ld_web       <= 1'b1;
            case (state)
                S_IDLE: if (wb.wbs_cyc_i && wb.wbs_stb_i && hit) begin
                    req_off <= off;
                    req_we  <= wb.wbs_we_i;
                    // Window accesses the loader cannot serve take the REG path
                    // so every non-SRAM access acks with the same latency.
                    state   <= S_REG;
                    if (is_mem && !run) begin
                        ld_addr <= off[ADDR_W+1:2];
                        if (wb.wbs_we_i) begin
                            ld_din   <= wb.wbs_dat_i[DATA_W-1:0];
                            ld_wmask <= wb.wbs_sel_i[1:0];
                            ld_csb   <= 1'b0;
                            ld_web   <= 1'b0;
                            state    <= S_MWR;
                        end else begin
`ifdef PROG_LOADER_READBACK_EN
                            ld_csb <= 1'b0;
                            state  <= S_MRD;
`endif
                        end
                    end
                end
                S_MWR: begin
                    if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
                    wb.wbs_ack_o <= 1'b1;
                    state        <= S_DONE;
                end
`ifdef PROG_LOADER_READBACK_EN
                S_MRD: state <= S_MWAIT;
                S_MWAIT: begin
                    wb.wbs_dat_o <= {{(32-DATA_W){1'b0}}, mem_dout};
                    wb.wbs_ack_o <= 1'b1;
                    state        <= S_DONE;
                end
`endif
                S_REG: begin
                    if (req_we) begin
                        if (req_off == CTRL_OFF) run <= wb.wbs_dat_i[0];
                    end else begin
                        case (req_off)
                            CTRL_OFF:   wb.wbs_dat_o <= {31'b0, run};
                            STATUS_OFF: wb.wbs_dat_o <= {{(16-CNT_W){1'b0}}, count, 15'b0, run};
                            default:    wb.wbs_dat_o <= '0;
                        endcase
                    end
                    wb.wbs_ack_o <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    mem_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
        .run       (run),
        .ld_addr   (ld_addr),
        .ld_din    (ld_din),
        .ld_csb    (ld_csb),
        .ld_web    (ld_web),
        .ld_wmask  (ld_wmask),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_csb   (cpu_csb),
        .cpu_web   (cpu_web),
        .cpu_din   (cpu_din),
        .mem_dout  (mem_dout),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_csb   (mem_csb),
        .mem_web   (mem_web),
        .mem_wmask (mem_wmask)
    );
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a transaction-level model of the
// address map, the SRAM contents, RUN and the saturating load count.
module tb_prog_loader;
    import prog_loader_pkg::*;
`ifdef PROG_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  cpu_addr = '0;
    logic [15:0] cpu_dout = '0;
    logic        cpu_csb = 1'b1;
    logic        cpu_web = 1'b1;
    logic [15:0] cpu_din;
    logic [9:0]  mem_addr;
    logic [15:0] mem_din;
    logic        mem_csb, mem_web;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_dout = '0;
    logic        cpu_rst_o;

    prog_loader_if wb();

    prog_loader #(.ADDR_W(10), .DATA_W(16), .BASE_ADR(BASE)) dut (
        .clk(clk), .rst(rst), .wb(wb),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_csb(cpu_csb), .cpu_web(cpu_web),
        .cpu_din(cpu_din), .mem_addr(mem_addr), .mem_din(mem_din), .mem_csb(mem_csb),
        .mem_web(mem_web), .mem_wmask(mem_wmask), .mem_dout(mem_dout), .cpu_rst_o(cpu_rst_o)
    );

    always #5 clk = ~clk;

    // Byte-masked SRAM macro pair; read data registered one cycle after the strobe.
    logic [15:0] sram [1024] = '{default: 16'h0};
    always @(posedge clk) begin
        if (!mem_csb) begin
            if (!mem_web) begin
                if (mem_wmask[0]) sram[mem_addr][7:0]  <= mem_din[7:0];
                if (mem_wmask[1]) sram[mem_addr][15:8] <= mem_din[15:8];
            end else begin
                mem_dout <= sram[mem_addr];
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] m_mem [1024] = '{default: 16'h0};
    logic        m_run = 1'b0;
    int          m_cnt = 0;
    int          n_wr = 0;
    logic [31:0] m_rd = '0;

    logic [9:0]  s_addr;
    logic [15:0] s_din;
    logic [1:0]  s_wmask;
    logic        s_web, s_crst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [11:0] off, input logic [3:0] sel,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat, output int nstb);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_sel_i = sel;
        wb.wbs_adr_i = BASE + {20'h0, off};
        wb.wbs_dat_i = wd;
        lat = 0;
        nstb = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!mem_csb) begin
                nstb++;
                s_addr = mem_addr; s_din = mem_din; s_wmask = mem_wmask; s_web = mem_web;
            end
            s_crst = cpu_rst_o;
        end while (!wb.wbs_ack_o && lat < 12);
        rd = wb.wbs_dat_o;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
    endtask

    task automatic do_op(input logic we, input logic [11:0] off, input logic [3:0] sel, input logic [31:0] wd);
        logic [31:0] rd;
        int lat, nstb, e_lat, e_stb;
        logic is_mem, old_run;
        logic [9:0] wa;
        is_mem  = (off <= 12'h7FC);
        wa      = off[11:2];
        old_run = m_run;
        e_lat = 2;
        e_stb = 0;
        if (is_mem && !m_run) begin
            if (we) e_stb = 1;
            else if (RB) begin e_lat = 3; e_stb = 1; end
        end
        if (!we) begin
            if (is_mem)               m_rd = (!m_run && RB) ? {16'h0, m_mem[wa]} : 32'h0;
            else if (off == 12'h800)  m_rd = {31'h0, m_run};
            else if (off == 12'h804)  m_rd = {5'h0, m_cnt[10:0], 15'h0, m_run};
            else                      m_rd = 32'h0;
        end
        xfer(we, off, sel, wd, rd, lat, nstb);
        chk("ack_latency", lat, e_lat);
        chk("sram_strobes", nstb, e_stb);
        chk("rdata", rd, m_rd);
        if (e_stb == 1) begin
            chk("strobe_addr", {22'h0, s_addr}, {22'h0, wa});
            chk("strobe_web", {31'h0, s_web}, {31'h0, !we});
            if (we) begin
                chk("strobe_din", {16'h0, s_din}, {16'h0, wd[15:0]});
                chk("strobe_wmask", {30'h0, s_wmask}, {30'h0, sel[1:0]});
            end
        end
        chk("cpu_rst_at_ack", {31'h0, s_crst}, {31'h0, !old_run});
        if (we && is_mem && !m_run) begin
            if (sel[0]) m_mem[wa][7:0]  = wd[7:0];
            if (sel[1]) m_mem[wa][15:8] = wd[15:8];
            n_wr++;
            if (m_cnt < 2047) m_cnt++;
        end
        if (we && off == 12'h800) m_run = wd[0];
        @(posedge clk); #1;
        chk("cpu_rst_after", {31'h0, cpu_rst_o}, {31'h0, !m_run});
    endtask

    initial begin #5_000_000; $display("FAIL watchdog: run did not finish"); $fatal(1); end

    initial begin : main
        int k;
        logic [15:0] v;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = '0;   wb.wbs_adr_i = '0;   wb.wbs_dat_i = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rst", {31'h0, cpu_rst_o}, 32'h1);
        chk("rst_csb", {31'h0, mem_csb}, 32'h1);
        chk("rst_web", {31'h0, mem_web}, 32'h1);
        chk("rst_wmask", {30'h0, mem_wmask}, 32'h0);
        chk("rst_addr", {22'h0, mem_addr}, 32'h0);
        chk("rst_din", {16'h0, mem_din}, 32'h0);
        chk("rst_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
        chk("rst_dat", wb.wbs_dat_o, 32'h0);
        rst = 1'b0;
        do_op(0, 12'h804, 4'hF, 0);
        chk("status_after_reset", wb.wbs_dat_o, 32'h0);

        do_op(1, 12'h010, 4'b0011, 32'h0000_BEEF);
        do_op(1, 12'h010, 4'b0001, 32'h0000_12AB);
        chk("sram_beab", {16'h0, sram[4]}, 32'h0000_BEAB);
        do_op(0, 12'h010, 4'hF, 0);
        chk("readback_beab", wb.wbs_dat_o, RB ? 32'h0000_BEAB : 32'h0);

        // CPU requests are dropped while the loader owns the port.
        cpu_addr = 10'd5; cpu_dout = 16'hDEAD; cpu_web = 1'b0; cpu_csb = 1'b0;
        #1;
        chk("drop_csb", {31'h0, mem_csb}, 32'h1);
        chk("drop_cpu_din", {16'h0, cpu_din}, 32'h0);
        @(posedge clk); #1;
        cpu_csb = 1'b1; cpu_web = 1'b1;
        chk("drop_sram", {16'h0, sram[5]}, {16'h0, m_mem[5]});

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: do_op(1, 12'($urandom_range(0, 15) * 4), 4'($urandom), $urandom);
                1: do_op(0, 12'($urandom_range(0, 15) * 4), 4'hF, 0);
                2: do_op(1, 12'h800, 4'hF, {31'h0, ($urandom_range(0, 3) == 0)});
                3: do_op(0, 12'h800, 4'hF, 0);
                4: do_op(0, 12'h804, 4'hF, 0);
                5: do_op(1, 12'h804, 4'hF, $urandom);
                default: do_op(1'($urandom_range(0, 1)), 12'(12'h808 + $urandom_range(0, 500) * 4), 4'hF, $urandom);
            endcase
        end

        do_op(1, 12'h800, 4'hF, 32'h1);
        cpu_addr = 10'd4; cpu_web = 1'b1; cpu_csb = 1'b0;
        #1;
        chk("pt_addr", {22'h0, mem_addr}, 32'h4);
        chk("pt_csb", {31'h0, mem_csb}, 32'h0);
        chk("pt_wmask", {30'h0, mem_wmask}, 32'h3);
        @(posedge clk); #1;
        chk("pt_cpu_din", {16'h0, cpu_din}, {16'h0, m_mem[4]});
        v = 16'($urandom);
        cpu_addr = 10'd7; cpu_dout = v; cpu_web = 1'b0;
        @(posedge clk); #1;
        cpu_csb = 1'b1; cpu_web = 1'b1;
        m_mem[7] = v;
        chk("pt_cpu_write", {16'h0, sram[7]}, {16'h0, v});
        do_op(1, 12'h010, 4'hF, 32'h0000_FFFF);
        chk("run_wb_write_ignored", {16'h0, sram[4]}, {16'h0, m_mem[4]});
        do_op(0, 12'h010, 4'hF, 0);
        do_op(0, 12'h804, 4'hF, 0);
        do_op(1, 12'h800, 4'hF, 32'h0);

        while (n_wr < 2050) do_op(1, 12'($urandom_range(0, 511) * 4), 4'($urandom), $urandom);
        do_op(0, 12'h804, 4'hF, 0);
        chk("status_saturated", wb.wbs_dat_o, 32'h07FF_0000);

        // Reset while the loader is mid-read.
        wb.wbs_we_i = 1'b0; wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = BASE + 32'h10;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1;
        @(posedge clk); #1;
        chk("mrd_csb", {31'h0, mem_csb}, {31'h0, !RB});
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_csb", {31'h0, mem_csb}, 32'h1);
        chk("rst_mid_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
        rst = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_mid_noack", {31'h0, wb.wbs_ack_o}, 32'h0);
        end
        m_run = 1'b0; m_cnt = 0; n_wr = 0; m_rd = '0;
        do_op(1, 12'h020, 4'b0011, 32'h0000_A5C3);
        do_op(0, 12'h804, 4'hF, 0);
        chk("post_rst_status", wb.wbs_dat_o, 32'h0001_0000);
        chk("post_rst_sram", {16'h0, sram[8]}, 32'h0000_A5C3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
